// File: rtl/alu_control_mdu.sv
// alu_control_mdu: widened ALU control decode plus an iterative multiply/divide unit owning HI/LO.
// Decode is combinational; the MDU runs IDLE -> RUN (one bit per cycle) -> FIX (sign fix, HI/LO write).
module alu_control_mdu #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic              flush,
   input  logic [1:0]        alu_op,
   input  logic [5:0]        funct,
   input  logic [WIDTH-1:0]  rs_val,
   input  logic [WIDTH-1:0]  rt_val,
   output logic [CTRL_W-1:0] alu_control,
   output logic              illegal,
   output logic              mdu_sel,
   output logic [WIDTH-1:0]  mdu_result,
   output logic              stall,
   output logic              busy
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] hi, lo, acc, q, m, ma, mb, qr, rr;
   logic is_div, neg_res, neg_rem, dz;
   logic is_md, is_mfhi, is_mflo, accept, sa, sb;
   logic [3:0] code;
   logic [WIDTH:0] sum, sh, diff;
   logic [2*WIDTH-1:0] prod;
   always_comb begin
      code = 4'b0000;
      illegal = 1'b0;
      is_md = 1'b0;
      case (alu_op)
         2'b00: code = 4'b0010;
         2'b01: code = 4'b0110;
         2'b11: illegal = 1'b1;
         default: case (funct)
            6'b100000, 6'b100001: code = 4'b0010;
            6'b100010, 6'b100011: code = 4'b0110;
            6'b100100: code = 4'b0000;
            6'b100101: code = 4'b0001;
            6'b100110: code = 4'b0011;
            6'b100111: code = 4'b1100;
            6'b101010: code = 4'b0111;
            6'b101011: code = 4'b1111;
            6'b011000, 6'b011001, 6'b011010, 6'b011011,
            6'b010000, 6'b010001, 6'b010010, 6'b010011: is_md = 1'b1;
            default: illegal = 1'b1;
         endcase
      endcase
   end
   assign alu_control = CTRL_W'(code);
   assign is_mfhi = (alu_op == 2'b10) && (funct == 6'b010000);
   assign is_mflo = (alu_op == 2'b10) && (funct == 6'b010010);
   assign mdu_sel = valid & (is_mfhi | is_mflo);
   assign mdu_result = is_mfhi ? hi : is_mflo ? lo : '0;
   assign busy = state != IDLE;
   assign stall = valid & busy & is_md;
   assign accept = valid & ~stall & ~flush;
   assign sa = ~funct[0] & rs_val[WIDTH-1];
   assign sb = ~funct[0] & rt_val[WIDTH-1];
   assign ma = sa ? -rs_val : rs_val;
   assign mb = sb ? -rt_val : rt_val;
   assign sum = {1'b0, acc} + {1'b0, m & {WIDTH{q[0]}}};
   assign sh = {acc, q[WIDTH-1]};
   assign diff = sh - {1'b0, m};
   assign prod = {acc, q};
   assign qr = neg_res ? -q : q;
   // a zero divisor leaves the dividend magnitude in acc, so the remainder fix restores rs_val exactly
   assign rr = neg_rem ? -acc : acc;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         hi <= '0;
         lo <= '0;
         acc <= '0;
         q <= '0;
         m <= '0;
         is_div <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         dz <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: if (accept && is_md) begin
               if (funct == 6'b010001) hi <= rs_val;
               if (funct == 6'b010011) lo <= rs_val;
               if (funct[5:2] == 4'b0110) begin
                  state <= RUN;
                  cnt <= '0;
                  acc <= '0;
                  m <= funct[1] ? mb : ma;
                  q <= funct[1] ? ma : mb;
                  is_div <= funct[1];
                  neg_res <= sa ^ sb;
                  neg_rem <= sa;
                  dz <= rt_val == '0;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) state <= FIX;
               if (is_div) begin
                  acc <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                  q <= {q[WIDTH-2:0], ~diff[WIDTH]};
               end else begin
                  acc <= sum[WIDTH:1];
                  q <= {sum[0], q[WIDTH-1:1]};
               end
            end
            FIX: begin
               state <= IDLE;
               cnt <= '0;
               if (is_div) begin
                  hi <= rr;
                  lo <= dz ? '1 : qr;
               end else {hi, lo} <= neg_res ? -prod : prod;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
Next-generation ALU control for the 32-bit MIPS core. It widens the ALU control code and decodes additional R-type functs. It also adds an iterative multiply/divide unit (MDU) that owns the HI/LO registers and stalls the pipeline while busy. It sits in EX beside the ALU; the decode path is combinational and the MDU is sequential.

Parameters:
WIDTH, 32, operand/HI/LO width (even, >=8)
CTRL_W, 4, ALU control code width (>=4)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid  input  1  instruction in EX is live
flush  input  1  cancel in-flight MDU op
alu_op  input  2  main-decoder ALU op class
funct  input  6  R-type funct field
rs_val  input  WIDTH  rs operand
rt_val  input  WIDTH  rt operand
alu_control  output  CTRL_W  ALU operation code
illegal  output  1  unsupported alu_op/funct
mdu_sel  output  1  EX result comes from mdu_result (mfhi/mflo)
mdu_result  output  WIDTH  HI (mfhi) or LO (mflo), else 0
stall  output  1  hold pipeline this cycle
busy  output  1  MDU iterating

Behaviour:
- Decode is combinational and fully specified; outputs are never X. Codes are zero-extended to CTRL_W.
- alu_op 00 -> ADD 0010; 01 -> SUB 0110; 11 -> 0000 with illegal=1.
- alu_op 10 -> add/addu (100000/100001) 0010; sub/subu (100010/100011) 0110; and 0000; or 0001; xor (100110) 0011; nor (100111) 1100; slt 0111; sltu (101011) 1111.
- alu_op 10, MDU functs (mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011) -> alu_control 0000, illegal=0.
- alu_op 10, any other funct -> 0000 with illegal=1.
- mdu_sel = valid & (mfhi|mflo). mdu_result = HI for mfhi, LO for mflo, 0 otherwise.
- stall = valid & busy & (any MDU funct with alu_op 10). Non-MDU instructions never stall.
- An instruction is accepted when valid & ~stall & ~flush.
- Accepted mthi/mtlo writes rs_val to HI/LO at that edge.
- Accepted mult/multu/div/divu latches operands and enters RUN.
- FSM states: IDLE -> RUN (WIDTH cycles, one bit per cycle: shift-add multiply, restoring divide on magnitudes) -> FIX (1 cycle: sign correction, HI/LO write) -> IDLE.
- busy=1 in RUN and FIX, so it is high for exactly WIDTH+1 cycles, starting the cycle after acceptance. HI/LO update at the final FIX edge; busy=0 the next cycle.
- Signed ops: multiply by operand magnitudes; product negated if signs differ. Quotient is negative if signs differ; remainder takes the dividend's sign.
- mult: {HI,LO} = full 2*WIDTH product.
- div: LO = quotient, HI = remainder.
- Divide by zero: HI = rs_val, LO = all ones (signed and unsigned). Still takes full latency.
- Signed MIN/-1: LO = MIN, HI = 0.
- flush: any state -> IDLE next edge; busy=0; HI/LO keep their pre-op values. A flush in the same cycle as an issue blocks acceptance.
- Reset, including mid-operation: state IDLE, iteration counter 0, HI=0, LO=0, busy=0, all internal operand regs 0.
- Iteration counter is clog2(WIDTH)+1 bits and never wraps past WIDTH.

Test Plan:
- Decode sweep: every listed alu_op/funct -> stated code and illegal value. funct 111111 with alu_op 10 -> 0000, illegal=1. alu_op 11 -> illegal=1.
- mult rs=FFFFFFFD (-3), rt=5 -> busy for 33 cycles, then HI=FFFFFFFF, LO=FFFFFFF1. multu FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
- div -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. div 80000000/FFFFFFFF -> LO=80000000, HI=0. divu 7/0 -> HI=00000007, LO=FFFFFFFF.
- mflo issued the cycle after a mult is accepted -> stall=1 for 33 cycles, then mdu_sel=1 with mdu_result = new LO. Independent add issued during busy -> stall=0.
- mthi 12345678 then mfhi -> 12345678, with no stall.
- flush at RUN cycle 10 -> busy=0 next cycle, HI/LO unchanged. rst_n low mid-RUN -> HI=LO=0, busy=0 immediately, without waiting for a clock edge.
